// File: rtl/alu_rs_pkg.sv
// Shared widths, opcode encodings and the reservation-station entry layout.
package alu_rs_pkg;

    localparam int unsigned WORD      = 32;
    localparam int unsigned OPT_W     = 6;
    localparam int unsigned ROB_IDX_W = 4;
    localparam int unsigned RS_SIZE   = 16;
    localparam int unsigned RS_IDX_W  = $clog2(RS_SIZE);
    localparam int unsigned CNT_W     = RS_IDX_W + 1;

    localparam logic [WORD-1:0] ZERO_WORD = '0;
    localparam logic            TRUE      = 1'b1;
    localparam logic            FALSE     = 1'b0;

    localparam logic [OPT_W-1:0] OPT_NOP  = 6'd0;
    localparam logic [OPT_W-1:0] OPT_ADD  = 6'd1;
    localparam logic [OPT_W-1:0] OPT_ADDI = 6'd2;
    localparam logic [OPT_W-1:0] OPT_SUB  = 6'd3;
    localparam logic [OPT_W-1:0] OPT_AND  = 6'd4;
    localparam logic [OPT_W-1:0] OPT_OR   = 6'd5;
    localparam logic [OPT_W-1:0] OPT_XOR  = 6'd6;
    localparam logic [OPT_W-1:0] OPT_BEQ  = 6'd7;
    localparam logic [OPT_W-1:0] OPT_BNE  = 6'd8;

    typedef struct packed {
        logic                 busy;
        logic [OPT_W-1:0]     opt;
        logic                 q1_pend;
        logic [ROB_IDX_W-1:0] q1;
        logic [WORD-1:0]      v1;
        logic                 q2_pend;
        logic [ROB_IDX_W-1:0] q2;
        logic [WORD-1:0]      v2;
        logic [WORD-1:0]      imm;
        logic [ROB_IDX_W-1:0] rob_idx;
    } rs_entry_t;

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Lowest-set-bit finder: reports whether any bit is set and the index of the lowest one.
module rs_prio_enc #(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic [N-1:0]     i_vec,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds ops until operands arrive, issues lowest ready entry.
module alu_rs
    import alu_rs_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 clr,
    input  logic                 disp_valid,
    input  logic [OPT_W-1:0]     disp_opt,
    input  logic                 disp_q1_pend,
    input  logic [ROB_IDX_W-1:0] disp_q1,
    input  logic [WORD-1:0]      disp_v1,
    input  logic                 disp_q2_pend,
    input  logic [ROB_IDX_W-1:0] disp_q2,
    input  logic [WORD-1:0]      disp_v2,
    input  logic [WORD-1:0]      disp_imm,
    input  logic [ROB_IDX_W-1:0] disp_rob_idx,
    output logic                 rs_full,
    input  logic                 cdb_alu_valid,
    input  logic [ROB_IDX_W-1:0] cdb_alu_src,
    input  logic [WORD-1:0]      cdb_alu_val,
    input  logic                 cdb_lsb_valid,
    input  logic [ROB_IDX_W-1:0] cdb_lsb_src,
    input  logic [WORD-1:0]      cdb_lsb_val,
    output logic                 alu_en,
    output logic [OPT_W-1:0]     alu_opt,
    output logic [WORD-1:0]      alu_val1,
    output logic [WORD-1:0]      alu_val2,
    output logic [WORD-1:0]      alu_imm,
    output logic [ROB_IDX_W-1:0] alu_rob_idx
);

    rs_entry_t            r_ent [RS_SIZE];
    logic [CNT_W-1:0]     r_cnt;

    logic [RS_SIZE-1:0]   w_free_vec;
    logic [RS_SIZE-1:0]   w_ready_vec;
    logic                 w_free_found;
    logic [RS_IDX_W-1:0]  w_free_idx;
    logic                 w_ready_found;
    logic [RS_IDX_W-1:0]  w_ready_idx;
    logic                 w_accept;
    logic                 w_issue;
    rs_entry_t            w_disp_ent;

    // Free and ready vectors from registered entry state.
    always_comb begin
        w_free_vec  = '0;
        w_ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_free_vec[i]  = !r_ent[i].busy;
            w_ready_vec[i] = r_ent[i].busy && !r_ent[i].q1_pend && !r_ent[i].q2_pend;
        end
    end

    rs_prio_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_alloc (
        .i_vec   (w_free_vec),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    rs_prio_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_select (
        .i_vec   (w_ready_vec),
        .o_found (w_ready_found),
        .o_idx   (w_ready_idx)
    );

    assign rs_full  = (r_cnt == CNT_W'(RS_SIZE));
    assign w_accept = rdy && !clr && disp_valid && !rs_full && w_free_found;
    assign w_issue  = rdy && !clr && w_ready_found;

    // Incoming entry with same-cycle CDB bypass; ALU CDB takes precedence.
    always_comb begin
        w_disp_ent         = '0;
        w_disp_ent.busy    = TRUE;
        w_disp_ent.opt     = disp_opt;
        w_disp_ent.q1_pend = disp_q1_pend;
        w_disp_ent.q1      = disp_q1;
        w_disp_ent.v1      = disp_v1;
        w_disp_ent.q2_pend = disp_q2_pend;
        w_disp_ent.q2      = disp_q2;
        w_disp_ent.v2      = disp_v2;
        w_disp_ent.imm     = disp_imm;
        w_disp_ent.rob_idx = disp_rob_idx;
        if (disp_q1_pend) begin
            if (cdb_alu_valid && cdb_alu_src == disp_q1) begin
                w_disp_ent.q1_pend = FALSE;
                w_disp_ent.v1      = cdb_alu_val;
            end else if (cdb_lsb_valid && cdb_lsb_src == disp_q1) begin
                w_disp_ent.q1_pend = FALSE;
                w_disp_ent.v1      = cdb_lsb_val;
            end
        end
        if (disp_q2_pend) begin
            if (cdb_alu_valid && cdb_alu_src == disp_q2) begin
                w_disp_ent.q2_pend = FALSE;
                w_disp_ent.v2      = cdb_alu_val;
            end else if (cdb_lsb_valid && cdb_lsb_src == disp_q2) begin
                w_disp_ent.q2_pend = FALSE;
                w_disp_ent.v2      = cdb_lsb_val;
            end
        end
    end

    // Entry storage, wakeup, issue and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_ent[i] <= '0;
            end
            r_cnt       <= '0;
            alu_en      <= FALSE;
            alu_opt     <= '0;
            alu_val1    <= ZERO_WORD;
            alu_val2    <= ZERO_WORD;
            alu_imm     <= ZERO_WORD;
            alu_rob_idx <= '0;
        end else if (!rdy) begin
            alu_en <= FALSE;
        end else if (clr) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_ent[i].busy <= FALSE;
            end
            r_cnt  <= '0;
            alu_en <= FALSE;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_ent[i].busy && r_ent[i].q1_pend) begin
                    if (cdb_alu_valid && cdb_alu_src == r_ent[i].q1) begin
                        r_ent[i].q1_pend <= FALSE;
                        r_ent[i].v1      <= cdb_alu_val;
                    end else if (cdb_lsb_valid && cdb_lsb_src == r_ent[i].q1) begin
                        r_ent[i].q1_pend <= FALSE;
                        r_ent[i].v1      <= cdb_lsb_val;
                    end
                end
                if (r_ent[i].busy && r_ent[i].q2_pend) begin
                    if (cdb_alu_valid && cdb_alu_src == r_ent[i].q2) begin
                        r_ent[i].q2_pend <= FALSE;
                        r_ent[i].v2      <= cdb_alu_val;
                    end else if (cdb_lsb_valid && cdb_lsb_src == r_ent[i].q2) begin
                        r_ent[i].q2_pend <= FALSE;
                        r_ent[i].v2      <= cdb_lsb_val;
                    end
                end
            end
            alu_en <= w_issue;
            if (w_issue) begin
                r_ent[w_ready_idx].busy <= FALSE;
                alu_opt     <= r_ent[w_ready_idx].opt;
                alu_val1    <= r_ent[w_ready_idx].v1;
                alu_val2    <= r_ent[w_ready_idx].v2;
                alu_imm     <= r_ent[w_ready_idx].imm;
                alu_rob_idx <= r_ent[w_ready_idx].rob_idx;
            end
            if (w_accept) begin
                r_ent[w_free_idx] <= w_disp_ent;
            end
            r_cnt <= r_cnt + CNT_W'(w_accept) - CNT_W'(w_issue);
        end
    end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station and issue scheduler in front of the combinational ALU.
- Accepts decoded ALU/branch ops from dispatch and holds them until both source operands are valid.
- Wakes operands by snooping the ALU and LSB common data buses (CDBs).
- Issues at most one ready op per cycle to the ALU, via registered outputs.

Parameters:
- RS_SIZE, 16: number of entries; must be a power of two.
- RS_IDX_W, 4: width of an entry index, equal to log2(RS_SIZE).
- ROB_IDX_W, 4: width of a ROB tag; taken from the shared package.
- OPT_W, 6: width of the internal opcode; taken from the shared package.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (asserted when 0)
- rdy  in  1  global ready; 0 freezes the whole block
- clr  in  1  flush on branch mispredict; empties the station
- disp_valid  in  1  dispatch request
- disp_opt  in  OPT_W  opcode
- disp_q1_pend  in  1  rs1 not yet available
- disp_q1  in  ROB_IDX_W  producer tag for rs1
- disp_v1  in  32  rs1 value (valid when disp_q1_pend=0)
- disp_q2_pend  in  1  rs2 not yet available
- disp_q2  in  ROB_IDX_W  producer tag for rs2
- disp_v2  in  32  rs2 value (valid when disp_q2_pend=0)
- disp_imm  in  32  immediate
- disp_rob_idx  in  ROB_IDX_W  destination ROB tag
- rs_full  out  1  no free entry
- cdb_alu_valid  in  1  ALU CDB broadcast valid
- cdb_alu_src  in  ROB_IDX_W  ALU CDB tag
- cdb_alu_val  in  32  ALU CDB value
- cdb_lsb_valid  in  1  LSB CDB broadcast valid
- cdb_lsb_src  in  ROB_IDX_W  LSB CDB tag
- cdb_lsb_val  in  32  LSB CDB value
- alu_en  out  1  issue valid, registered
- alu_opt  out  OPT_W  issued opcode
- alu_val1  out  32  issued rs1 value
- alu_val2  out  32  issued rs2 value
- alu_imm  out  32  issued immediate
- alu_rob_idx  out  ROB_IDX_W  issued ROB tag

Behaviour:
- Entry state: busy, opt, q1_pend, q1, v1, q2_pend, q2, v2, imm, rob_idx.
- Count register: cnt, RS_IDX_W+1 bits wide.
- Reset (rst=0 at posedge):
  - all busy bits cleared, cnt=0;
  - alu_en=0, all alu_* data outputs 0;
  - rs_full=0.
  - Reset overrides every other input, including mid-operation.
- clr=1 (with rst=1, rdy=1):
  - all busy bits cleared, cnt=0, alu_en=0 next cycle;
  - the same-cycle dispatch is dropped;
  - no issue happens that cycle.
- rdy=0:
  - all state holds, including entries, cnt and alu_* data;
  - alu_en goes 0 at the next edge;
  - dispatch and CDB inputs are ignored.
- rs_full = (cnt == RS_SIZE); combinational from the registered cnt.
  - A dispatch while rs_full=1 is ignored; the dispatcher must not assert it.
- Dispatch:
  - Accepted when disp_valid=1, rs_full=0, clr=0 and rdy=1.
  - Written into the lowest-index entry whose busy bit is 0 in registered state.
  - An entry freed by issue in the same cycle cannot be reused that cycle.
- Same-cycle bypass at dispatch: for each pending operand whose tag matches a valid CDB in the same cycle, store the CDB value and clear its pend bit.
  - If both CDBs match the same tag, the ALU CDB wins (the ROB guarantees unique tags, so this is defensive only).
- Wakeup: every busy entry with qN_pend=1 and qN == a valid CDB src captures that CDB value and clears its pend bit at the edge.
- Ready: busy && !q1_pend && !q2_pend, evaluated on registered state.
  - A value woken in cycle t makes the entry issueable in cycle t+1.
- Issue:
  - Fixed priority: the lowest-index ready entry is issued.
  - At the edge, alu_* are loaded from that entry, alu_en=1, and its busy bit is cleared.
  - No ready entry: alu_en=0 and alu_* data hold their previous values.
- Latency: dispatch with both operands available at edge t gives alu_en=1 at edge t+1 at the earliest; the ALU result is on the CDB in the same cycle as alu_en.
- cnt_next = cnt + accept - issue. Simultaneous accept and issue leave cnt unchanged; this holds when full too (issue frees, dispatch blocked by rs_full).
- No wrap-around: the allocator and selector are priority encoders, not pointers.

Decomposition:
- Shared package / utils:
  - OPT_* encodings, OPT_W;
  - WORD width, ROB_IDX_W, RS_SIZE;
  - ZERO_WORD, TRUE/FALSE.
- One sub-module, rs_prio_enc: parameterised lowest-set-bit finder over an RS_SIZE-bit vector, returning {found, index}.
  - Instantiated twice: free-slot allocation and ready-slot selection.

Test Plan:
- Reset, then dispatch ADDI with v1=5, imm=7, no pending operands, rob_idx=3 -> next cycle alu_en=1, alu_opt=ADDI, alu_val1=5, alu_imm=7, alu_rob_idx=3; the following cycle alu_en=0.
- Dispatch ADD with q1_pend, q1=2, v2=10; two cycles later cdb_lsb_valid, src=2, val=0x20 -> alu_en=1 exactly one cycle after the broadcast, alu_val1=0x20, alu_val2=10.
- Dispatch with q2_pend, q2=6 in the same cycle as cdb_alu_valid, src=6, val=9 -> bypass captured; issue next cycle with alu_val2=9.
- Fill 16 entries, all waiting on tag 1 -> rs_full=1 and a 17th dispatch is ignored. Broadcast tag 1 -> entries 0..15 issue in index order on consecutive cycles; rs_full drops after the first issue.
- With 4 entries busy: assert clr together with disp_valid -> cnt=0, alu_en=0, rs_full=0, and the dropped op is never issued. Also hold rdy=0 for 3 cycles with a ready entry -> no issue; issue occurs 1 cycle after rdy returns.
- Drive rst=0 while entries are pending and alu_en=1 -> all outputs 0 after one edge; no stale issue after rst returns to 1.
